// File: rtl/atm.sv
// Account/balance datapath of the crypto ATM: 16 accounts holding USD/BTC/ETH.
// The operation selected by the one-hot controller state executes on each rising edge of ready.
module atm #(
  parameter int NUM_ACC  = 16,
  parameter int INIT_USD = 1000,
  parameter int INIT_BTC = 10,
  parameter int INIT_ETH = 10,
  parameter int BTC_RATE = 50,
  parameter int ETH_RATE = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  accNumber,
  input  logic [3:0]  pin,
  input  logic [15:0] current_state,
  input  logic [1:0]  menuOption,
  input  logic [2:0]  currency_type_in,
  input  logic [2:0]  currency_type_2_in,
  input  logic [31:0] amount,
  input  logic        ready,
  input  logic [3:0]  destinationAcc,
  output logic [15:0] balance_dollars_out,
  output logic [15:0] balance_btc_out,
  output logic [15:0] balance_eth_out,
  output logic [3:0]  status_code
);

  localparam logic [15:0] S_IDLE     = 16'h0001;
  localparam logic [15:0] S_ACC_NUM  = 16'h0002;
  localparam logic [15:0] S_PIN      = 16'h0004;
  localparam logic [15:0] S_CONV_1   = 16'h0040;
  localparam logic [15:0] S_CONV_2   = 16'h0080;
  localparam logic [15:0] S_WD_AMT   = 16'h0200;
  localparam logic [15:0] S_TRANSFER = 16'h0400;
  localparam logic [15:0] S_TR_AMT   = 16'h1000;

  localparam logic [3:0] ST_ACC_OK    = 4'd1;
  localparam logic [3:0] ST_PIN_OK    = 4'd2;
  localparam logic [3:0] ST_PIN_BAD   = 4'd3;
  localparam logic [3:0] ST_OP_OK     = 4'd4;
  localparam logic [3:0] ST_INSUFF    = 4'd5;
  localparam logic [3:0] ST_BAD_CUR   = 4'd6;
  localparam logic [3:0] ST_NOT_AUTH  = 4'd7;
  localparam logic [3:0] ST_BAD_DEST  = 4'd8;
  localparam logic [3:0] ST_BAD_STATE = 4'd9;
  localparam logic [3:0] ST_OVERFLOW  = 4'd10;

  function automatic logic [15:0] pick(input logic [2:0][15:0] v, input logic [2:0] cur);
    case (cur)
      3'd0:    return v[0];
      3'd1:    return v[1];
      3'd2:    return v[2];
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] rate(input logic [2:0] cur);
    case (cur)
      3'd1:    return 16'(BTC_RATE);
      3'd2:    return 16'(ETH_RATE);
      default: return 16'd1;
    endcase
  endfunction

  function automatic logic [15:0] init_val(input int cur);
    case (cur)
      0:       return 16'(INIT_USD);
      1:       return 16'(INIT_BTC);
      default: return 16'(INIT_ETH);
    endcase
  endfunction

  // Per account: [0]=USD, [1]=BTC, [2]=ETH
  logic [2:0][15:0] bal_q [NUM_ACC];

  logic        auth_q, auth_d;
  logic [3:0]  acc_sel_q, acc_sel_d;
  logic [3:0]  dest_q, dest_d;
  logic [31:0] conv_amt_q, conv_amt_d;
  logic [3:0]  status_q, status_d;
  logic        ready_q;
  logic        trig;

  logic        wr_src, wr_dst;
  logic [3:0]  src_acc, dst_acc;
  logic [2:0]  src_cur, dst_cur;
  logic [15:0] src_val, dst_val;

  logic [2:0][15:0] own_bal, dest_bal;
  logic [15:0] src_bal, conv_dst_bal, xfer_dst_bal;
  logic        cur_bad, cur2_bad, conv_short, amt_short;
  logic [47:0] conv_prod, conv_credit, conv_sum;
  logic [16:0] xfer_sum;
  logic        unused_ok;

  assign trig         = ready & ~ready_q;
  assign own_bal      = bal_q[acc_sel_q];
  assign dest_bal     = bal_q[dest_q];
  assign src_bal      = pick(own_bal, currency_type_in);
  assign conv_dst_bal = pick(own_bal, currency_type_2_in);
  assign xfer_dst_bal = pick(dest_bal, currency_type_in);
  assign cur_bad      = currency_type_in > 3'd2;
  assign cur2_bad     = currency_type_2_in > 3'd2;
  assign conv_short   = (|conv_amt_q[31:16]) || (conv_amt_q[15:0] > src_bal);
  assign amt_short    = (|amount[31:16]) || (amount[15:0] > src_bal);
  assign conv_prod    = {16'd0, conv_amt_q} * {32'd0, rate(currency_type_in)};
  assign conv_sum     = {32'd0, conv_dst_bal} + conv_credit;
  assign xfer_sum     = {1'b0, xfer_dst_bal} + {1'b0, amount[15:0]};
  assign unused_ok    = ^menuOption;

  // Division by the fixed rates only, so each branch is a constant divider
  always_comb begin
    case (currency_type_2_in)
      3'd1:    conv_credit = conv_prod / 48'(BTC_RATE);
      3'd2:    conv_credit = conv_prod / 48'(ETH_RATE);
      default: conv_credit = conv_prod;
    endcase
  end

  always_comb begin
    auth_d     = auth_q;
    acc_sel_d  = acc_sel_q;
    dest_d     = dest_q;
    conv_amt_d = conv_amt_q;
    status_d   = status_q;
    wr_src     = 1'b0;
    wr_dst     = 1'b0;
    src_acc    = acc_sel_q;
    src_cur    = currency_type_in;
    src_val    = 16'd0;
    dst_acc    = acc_sel_q;
    dst_cur    = currency_type_2_in;
    dst_val    = 16'd0;

    if (current_state == S_IDLE) auth_d = 1'b0;

    if (trig) begin
      case (current_state)
        S_ACC_NUM: begin
          acc_sel_d = accNumber;
          auth_d    = 1'b0;
          status_d  = ST_ACC_OK;
        end
        S_PIN: begin
          auth_d   = (pin == acc_sel_q);
          status_d = (pin == acc_sel_q) ? ST_PIN_OK : ST_PIN_BAD;
        end
        S_CONV_1: begin
          conv_amt_d = amount;
          status_d   = ST_OP_OK;
        end
        S_CONV_2: begin
          if (!auth_q) status_d = ST_NOT_AUTH;
          else if (cur_bad || cur2_bad || currency_type_in == currency_type_2_in) status_d = ST_BAD_CUR;
          else if (conv_short) status_d = ST_INSUFF;
          else if (|conv_sum[47:16]) status_d = ST_OVERFLOW;
          else begin
            wr_src   = 1'b1;
            src_val  = src_bal - conv_amt_q[15:0];
            wr_dst   = 1'b1;
            dst_val  = conv_sum[15:0];
            status_d = ST_OP_OK;
          end
        end
        S_WD_AMT: begin
          if (!auth_q) status_d = ST_NOT_AUTH;
          else if (cur_bad) status_d = ST_BAD_CUR;
          else if (amt_short) status_d = ST_INSUFF;
          else begin
            wr_src   = 1'b1;
            src_val  = src_bal - amount[15:0];
            status_d = ST_OP_OK;
          end
        end
        S_TRANSFER: begin
          dest_d   = destinationAcc;
          status_d = ST_OP_OK;
        end
        S_TR_AMT: begin
          if (!auth_q) status_d = ST_NOT_AUTH;
          else if (cur_bad) status_d = ST_BAD_CUR;
          else if (dest_q == acc_sel_q) status_d = ST_BAD_DEST;
          else if (amt_short) status_d = ST_INSUFF;
          else if (xfer_sum[16]) status_d = ST_OVERFLOW;
          else begin
            wr_src   = 1'b1;
            src_val  = src_bal - amount[15:0];
            wr_dst   = 1'b1;
            dst_acc  = dest_q;
            dst_cur  = currency_type_in;
            dst_val  = xfer_sum[15:0];
            status_d = ST_OP_OK;
          end
        end
        default: status_d = ST_BAD_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auth_q     <= 1'b0;
      acc_sel_q  <= 4'd0;
      dest_q     <= 4'd0;
      conv_amt_q <= 32'd0;
      status_q   <= 4'd0;
      ready_q    <= 1'b0;
    end else begin
      auth_q     <= auth_d;
      acc_sel_q  <= acc_sel_d;
      dest_q     <= dest_d;
      conv_amt_q <= conv_amt_d;
      status_q   <= status_d;
      ready_q    <= ready;
    end
  end

  // Source and destination never hit the same cell on a commit
  always_ff @(posedge clk) begin
    for (int a = 0; a < NUM_ACC; a++) begin
      for (int c = 0; c < 3; c++) begin
        if (!rst_n) bal_q[a][c] <= init_val(c);
        else if (wr_src && src_acc == 4'(a) && src_cur == 3'(c)) bal_q[a][c] <= src_val;
        else if (wr_dst && dst_acc == 4'(a) && dst_cur == 3'(c)) bal_q[a][c] <= dst_val;
      end
    end
  end

  assign balance_dollars_out = auth_q ? own_bal[0] : 16'd0;
  assign balance_btc_out     = auth_q ? own_bal[1] : 16'd0;
  assign balance_eth_out     = auth_q ? own_bal[2] : 16'd0;
  assign status_code         = status_q;

endmodule

// File: tb/tb_atm.sv
// Scoreboard bench for atm: directed walk-through then randomized operations,
// checked against a high-level account model.
module tb_atm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  accNumber;
  logic [3:0]  pin;
  logic [15:0] current_state;
  logic [1:0]  menuOption;
  logic [2:0]  currency_type_in;
  logic [2:0]  currency_type_2_in;
  logic [31:0] amount;
  logic        ready;
  logic [3:0]  destinationAcc;
  logic [15:0] balance_dollars_out;
  logic [15:0] balance_btc_out;
  logic [15:0] balance_eth_out;
  logic [3:0]  status_code;

  atm dut (
    .clk(clk), .rst_n(rst_n), .accNumber(accNumber), .pin(pin),
    .current_state(current_state), .menuOption(menuOption),
    .currency_type_in(currency_type_in), .currency_type_2_in(currency_type_2_in),
    .amount(amount), .ready(ready), .destinationAcc(destinationAcc),
    .balance_dollars_out(balance_dollars_out), .balance_btc_out(balance_btc_out),
    .balance_eth_out(balance_eth_out), .status_code(status_code)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] IDLE = 16'h0001, ACC_NUM = 16'h0002, PIN_INPUT = 16'h0004,
                          SHOW = 16'h0010, CONV_1 = 16'h0040, CONV_2 = 16'h0080,
                          WD_AMT = 16'h0200, TRANSFER = 16'h0400, TR_AMT = 16'h1000;

  typedef struct {
    int          id;
    logic [15:0] cs;
    int          st;
    longint      u, b, e;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_txn    = 0;

  // Reference model: balances per account/currency, login and pending operands
  longint m_bal [16][3];
  bit     m_auth;
  int     m_acc, m_dest, m_status;
  longint m_conv;

  function automatic void check(string name, longint got, longint expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endfunction

  function automatic longint rate(int c);
    return (c == 0) ? 64'd1 : (c == 1) ? 64'd50 : 64'd20;
  endfunction

  function automatic longint mo(int c);
    return m_auth ? m_bal[m_acc][c] : 64'd0;
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < 16; a++) begin
      m_bal[a][0] = 1000; m_bal[a][1] = 10; m_bal[a][2] = 10;
    end
    m_auth = 0; m_acc = 0; m_dest = 0; m_conv = 0; m_status = 0;
  endfunction

  function automatic int onehot_idx(logic [15:0] cs);
    if ($countones(cs) != 1) return -1;
    for (int i = 0; i < 16; i++) if (cs[i]) return i;
    return -1;
  endfunction

  function automatic int model_apply(logic [15:0] cs, int accn, int pinv, int c1, int c2,
                                     longint amt, int dst);
    longint credit;
    case (onehot_idx(cs))
      1: begin m_acc = accn; m_auth = 0; return 1; end
      2: begin m_auth = (pinv == m_acc); return m_auth ? 2 : 3; end
      6: begin m_conv = amt; return 4; end
      7: begin
        if (!m_auth) return 7;
        if (c1 > 2 || c2 > 2 || c1 == c2) return 6;
        if (m_conv > 65535 || m_conv > m_bal[m_acc][c1]) return 5;
        credit = m_conv * rate(c1) / rate(c2);
        if (m_bal[m_acc][c2] + credit > 65535) return 10;
        m_bal[m_acc][c1] -= m_conv;
        m_bal[m_acc][c2] += credit;
        return 4;
      end
      9: begin
        if (!m_auth) return 7;
        if (c1 > 2) return 6;
        if (amt > 65535 || amt > m_bal[m_acc][c1]) return 5;
        m_bal[m_acc][c1] -= amt;
        return 4;
      end
      10: begin m_dest = dst; return 4; end
      12: begin
        if (!m_auth) return 7;
        if (c1 > 2) return 6;
        if (m_dest == m_acc) return 8;
        if (amt > 65535 || amt > m_bal[m_acc][c1]) return 5;
        if (m_bal[m_dest][c1] + amt > 65535) return 10;
        m_bal[m_acc][c1] -= amt;
        m_bal[m_dest][c1] += amt;
        return 4;
      end
      default: return 9;
    endcase
  endfunction

  // One operation: present inputs, raise ready, keep it high for 'hold' edges
  task automatic op(input logic [15:0] cs, input int accn, input int pinv, input int c1,
                    input int c2, input logic [31:0] amt, input int dst, input int hold);
    exp_t   e;
    longint a;
    @(negedge clk);
    current_state      = cs;
    accNumber          = 4'(accn);
    pin                = 4'(pinv);
    currency_type_in   = 3'(c1);
    currency_type_2_in = 3'(c2);
    amount             = amt;
    destinationAcc     = 4'(dst);
    menuOption         = 2'($urandom_range(0, 3));
    ready              = 1'b1;
    @(posedge clk);
    a = amt;
    m_status = model_apply(cs, accn, pinv, c1, c2, a, dst);
    n_txn++;
    e.id = n_txn; e.cs = cs; e.st = m_status; e.u = mo(0); e.b = mo(1); e.e = mo(2);
    exp_q.push_back(e);
    for (int k = 1; k < hold; k++) @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic login(input int a);
    op(ACC_NUM, a, 0, 0, 0, 32'd0, 0, 1);
    op(PIN_INPUT, 0, a, 0, 0, 32'd0, 0, 1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    current_state = IDLE;
    ready = 1'b0;
    @(posedge clk);
    m_auth = 0;
    @(posedge clk);
  endtask

  task automatic expect_now(input string name, input int st, input longint u,
                            input longint b, input longint e);
    @(negedge clk);
    check({name, "_status"}, status_code, st);
    check({name, "_usd"}, balance_dollars_out, u);
    check({name, "_btc"}, balance_btc_out, b);
    check({name, "_eth"}, balance_eth_out, e);
  endtask

  task automatic expect_model(input string name);
    expect_now(name, m_status, mo(0), mo(1), mo(2));
  endtask

  function automatic logic [31:0] rand_amt();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'd0;
    if (r == 1) return $urandom;
    if (r == 2) return 32'(65536 + $urandom_range(0, 100));
    return 32'($urandom_range(0, 300));
  endfunction

  function automatic int rand_cur();
    int r;
    r = $urandom_range(0, 9);
    return (r < 8) ? r % 3 : r - 5;
  endfunction

  // Monitor: every rising edge of ready outside reset yields one DUT response
  initial begin : monitor
    bit   mon_rq;
    exp_t e;
    mon_rq = 1'b0;
    forever begin
      @(posedge clk);
      if (rst_n && ready && !mon_rq) begin
        mon_rq = 1'b1;
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: got a response, expected none queued");
        end else begin
          e = exp_q.pop_front();
          check($sformatf("txn%0d_status", e.id), status_code, e.st);
          check($sformatf("txn%0d_usd", e.id), balance_dollars_out, e.u);
          check($sformatf("txn%0d_btc", e.id), balance_btc_out, e.b);
          check($sformatf("txn%0d_eth", e.id), balance_eth_out, e.e);
          $display("txn %0d state=%h status=%0d usd=%0d btc=%0d eth=%0d", e.id, e.cs,
                   status_code, balance_dollars_out, balance_btc_out, balance_eth_out);
        end
      end else begin
        mon_rq = rst_n ? ready : 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] cs;
    int          kind, a, d;
    rst_n = 1'b0; ready = 1'b0; current_state = ACC_NUM; accNumber = 4'd0; pin = 4'd0;
    menuOption = 2'd0; currency_type_in = 3'd0; currency_type_2_in = 3'd0;
    amount = 32'd0; destinationAcc = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_now("reset", 0, 0, 0, 0);

    login(0);
    expect_now("tp_login", 2, 1000, 10, 10);
    op(CONV_1, 0, 0, 0, 0, 32'd1, 0, 1);
    op(CONV_2, 0, 0, 1, 0, 32'd0, 0, 1);
    expect_now("tp_convert", 4, 1050, 9, 10);
    op(WD_AMT, 0, 0, 0, 0, 32'd100, 0, 1);
    expect_now("tp_withdraw", 4, 950, 9, 10);
    op(WD_AMT, 0, 0, 0, 0, 32'd5000, 0, 1);
    expect_now("tp_insufficient", 5, 950, 9, 10);
    op(TRANSFER, 0, 0, 0, 0, 32'd0, 1, 1);
    op(TR_AMT, 0, 0, 0, 0, 32'd100, 0, 1);
    expect_now("tp_transfer", 4, 850, 9, 10);
    go_idle();
    expect_now("tp_idle", 4, 0, 0, 0);
    login(1);
    op(SHOW, 0, 0, 0, 0, 32'd0, 0, 1);
    expect_now("tp_acc1", 9, 1100, 10, 10);
    op(PIN_INPUT, 0, 3, 0, 0, 32'd0, 0, 1);
    expect_now("tp_pin_bad", 3, 0, 0, 0);
    op(WD_AMT, 0, 0, 0, 0, 32'd10, 0, 1);
    expect_now("tp_not_auth", 7, 0, 0, 0);
    login(1);
    op(CONV_1, 0, 0, 0, 0, 32'd5, 0, 1);
    op(CONV_2, 0, 0, 0, 3, 32'd0, 0, 1);
    expect_now("tp_bad_cur", 6, 1100, 10, 10);
    op(TRANSFER, 0, 0, 0, 0, 32'd0, 1, 1);
    op(TR_AMT, 0, 0, 0, 0, 32'd10, 0, 1);
    expect_now("tp_bad_dest", 8, 1100, 10, 10);
    op(WD_AMT, 0, 0, 0, 0, 32'd7, 0, 5);
    expect_now("tp_hold", 4, 1093, 10, 10);
    op(16'h0003, 0, 0, 0, 0, 32'd0, 0, 1);
    expect_now("tp_not_onehot", 9, 1093, 10, 10);
    op(WD_AMT, 0, 0, 0, 0, 32'd0, 0, 1);
    expect_now("tp_zero_amount", 4, 1093, 10, 10);

    for (int it = 0; it < 300; it++) begin
      if (!m_auth && $urandom_range(0, 1) == 0) login(int'($urandom_range(0, 15)));
      kind = $urandom_range(0, 9);
      case (kind)
        0: op(ACC_NUM, int'($urandom_range(0, 15)), 0, 0, 0, 32'd0, 0, 1);
        1: begin
          a = ($urandom_range(0, 3) != 0) ? m_acc : int'($urandom_range(0, 15));
          op(PIN_INPUT, 0, a, 0, 0, 32'd0, 0, 1);
        end
        2, 3: begin
          op(CONV_1, 0, 0, 0, 0, rand_amt(), 0, 1);
          op(CONV_2, 0, 0, rand_cur(), rand_cur(), rand_amt(), 0, 1);
        end
        4, 5: op(WD_AMT, 0, 0, rand_cur(), 0, rand_amt(), 0, int'($urandom_range(1, 3)));
        6, 7: begin
          d = ($urandom_range(0, 3) == 0) ? m_acc : int'($urandom_range(0, 15));
          op(TRANSFER, 0, 0, 0, 0, 32'd0, d, 1);
          op(TR_AMT, 0, 0, rand_cur(), 0, rand_amt(), 0, 1);
        end
        8: begin
          cs = 16'h0001;
          if ($urandom_range(0, 1) == 1) cs = cs << $urandom_range(1, 15);
          else cs = 16'($urandom) | 16'h0006;
          op(cs, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), rand_cur(),
             rand_cur(), rand_amt(), int'($urandom_range(0, 15)), 1);
        end
        default: begin
          go_idle();
          expect_model("rand_idle");
        end
      endcase
    end
    expect_model("rand_final");

    // Reset asserted on the same edge as an operation strobe wins
    login(2);
    @(negedge clk);
    current_state = WD_AMT; currency_type_in = 3'd0; amount = 32'd50;
    ready = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_now("mid_reset", 0, 0, 0, 0);
    login(2);
    expect_now("post_reset_acc2", 2, 1000, 10, 10);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atm.md
Name: atm

Overview:
- Account/balance datapath of the crypto ATM.
- Stores USD, BTC and ETH balances and a PIN for 16 accounts.
- Executes the operation selected by the externally driven one-hot `current_state` on each rising edge of `ready`.
- Exposes the logged-in account's balances and a status code to the UI/controller FSM.

Parameters:
- NUM_ACC, 16, number of accounts (indexed by 4-bit account number).
- INIT_USD, 1000, reset USD balance of every account.
- INIT_BTC, 10, reset BTC balance of every account.
- INIT_ETH, 10, reset ETH balance of every account.
- BTC_RATE, 50, USD value of 1 BTC.
- ETH_RATE, 20, USD value of 1 ETH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- accNumber  in  4  account number to log in.
- pin  in  4  PIN entry.
- current_state  in  16  one-hot controller state: IDLE=bit0, ACC_NUM=bit1, PIN_INPUT=bit2, MENU=bit3, SHOW_BALANCES=bit4, CONVERT_CURRENCY=bit5, SELECT_CURRENCY_CONVERT_1=bit6, SELECT_CURRENCY_CONVERT_2=bit7, WITHDRAW=bit8, SELECT_AMOUNT_WITHDRAW=bit9, TRANSFER=bit10, SELECT_CURRENCY_TRANSFER=bit11, SELECT_AMOUNT_TRANSFER=bit12, ERROR=bit13, SUCCESS=bit14.
- menuOption  in  2  menu selection (informational; no action in this block).
- currency_type_in  in  3  source currency: USD=0, BTC=1, ETH=2, XRP=3, LTC=4.
- currency_type_2_in  in  3  destination currency for conversion (same encoding).
- amount  in  32  operation amount in units of the source currency.
- ready  in  1  operation strobe; acts on its rising edge.
- destinationAcc  in  4  transfer target account.
- balance_dollars_out  out  16  USD balance of the logged-in account, else 0.
- balance_btc_out  out  16  BTC balance of the logged-in account, else 0.
- balance_eth_out  out  16  ETH balance of the logged-in account, else 0.
- status_code  out  4  result of the last operation.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All accounts get INIT_USD/INIT_BTC/INIT_ETH.
  - auth=0, acc_sel=0, dest=0, conv_amt=0, ready_q=0, status_code=0.
- PIN of account n is the constant n; it is not modifiable.
- Operation trigger: at an edge where ready=1 and ready_q=0. ready_q <= ready every cycle. Holding ready high triggers one operation only.
- Commit timing: registers and status_code update at the trigger edge. Balance outputs are combinational reads of the registers for acc_sel, gated by auth, so they reflect the commit immediately after that edge.
- When current_state==IDLE, auth is cleared every cycle; no ready is needed.
- Operations at the trigger edge:
  - ACC_NUM: acc_sel<=accNumber, auth<=0, status=1 (ACC_OK).
  - PIN_INPUT: if pin==acc_sel then auth<=1, status=2 (PIN_OK); else auth<=0, status=3 (PIN_BAD).
  - SELECT_CURRENCY_CONVERT_1: conv_amt<=amount, status=4 (OP_OK).
  - SELECT_CURRENCY_CONVERT_2: source=currency_type_in, dest=currency_type_2_in.
    - Debit source by conv_amt.
    - Credit dest by (conv_amt*rate_src)/rate_dst, integer truncation; rate USD=1.
  - SELECT_AMOUNT_WITHDRAW: debit currency_type_in by amount.
  - TRANSFER: dest<=destinationAcc, status=4.
  - SELECT_AMOUNT_TRANSFER: debit acc_sel, credit dest, same currency currency_type_in, amount.
  - Any other state, including non-one-hot values: no change, status=9 (BAD_STATE).
- Error checks for convert/withdraw/transfer, applied in this priority order:
  - auth=0 → 7 (NOT_AUTH).
  - Currency >2 on either side, or convert source==dest → 6 (BAD_CURRENCY).
  - Transfer with dest==acc_sel → 8 (BAD_DEST).
  - Amount >65535 or > source balance → 5 (INSUFFICIENT).
  - Credit result >65535 → 10 (OVERFLOW).
  - Otherwise commit, status=4.
- On any error, no balance changes.
- amount=0 is legal: status=4, balances unchanged.
- All arithmetic is unsigned; 32-bit amount, products computed at 48 bits; balances are 16-bit and never wrap.
- Reset mid-operation overrides everything.

Test Plan:
- Reset, ACC_NUM acc 0 + ready, PIN_INPUT pin 0 + ready → status 2; outputs 1000/10/10.
- CONVERT_1 amount=1 + ready; CONVERT_2 BTC→USD + ready → status 4; USD=1050, BTC=9.
- SELECT_AMOUNT_WITHDRAW USD amount=100 + ready → USD=950. Then amount=5000 → status 5, USD stays 950.
- TRANSFER dest=1 + ready; SELECT_AMOUNT_TRANSFER USD 100 + ready → acc0 USD=850.
  - IDLE → outputs 0.
  - Log in acc 1 / pin 1, SHOW_BALANCES → 1100/10/10.
- PIN_INPUT pin 3 for acc 1 → status 3, outputs 0. Withdraw attempt → status 7.
- Logged in: convert with currency_type_2_in=XRP → status 6. Transfer to self → status 8. Ready held high for 5 cycles → exactly one debit.
